// File: rtl/dsp_update_sequencer.sv
// Arbitrates weight-controller and JTAG update requests and sequences single-lane or
// broadcast parameter writes into the DSP. Optional post-write settle gap: DSP_UPD_SETTLE_EN.
module dsp_update_sequencer #(
  parameter int CHANNEL_WIDTH = 16,
  parameter int DATA_BITS     = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wc_req,
  input  logic                             wc_bcast,
  input  logic [2:0]                       wc_sel,
  input  logic [$clog2(CHANNEL_WIDTH)-1:0] wc_chan,
  input  logic [4:0]                       wc_tap,
  input  logic [DATA_BITS-1:0]             wc_data,
  output logic                             wc_ack,
  input  logic                             jtag_req,
  input  logic                             jtag_bcast,
  input  logic [2:0]                       jtag_sel,
  input  logic [$clog2(CHANNEL_WIDTH)-1:0] jtag_chan,
  input  logic [4:0]                       jtag_tap,
  input  logic [DATA_BITS-1:0]             jtag_data,
  output logic                             jtag_ack,
  output logic                             upd_strobe,
  output logic [2:0]                       upd_sel,
  output logic [$clog2(CHANNEL_WIDTH)-1:0] upd_chan,
  output logic [4:0]                       upd_tap,
  output logic [DATA_BITS-1:0]             upd_data,
  output logic                             busy,
  output logic                             sel_err
);
  localparam int              CW           = $clog2(CHANNEL_WIDTH);
  localparam logic [CW-1:0]   LAST_LANE    = CW'(CHANNEL_WIDTH - 1);
  localparam logic [2:0]      SEL_MAX      = 3'd4;
  localparam logic [2:0]      SEL_CHAN_EST = 3'd3;

  if (CHANNEL_WIDTH < 2 || SETTLE_CYCLES < 1) begin : g_param_check
    $error("dsp_update_sequencer: CHANNEL_WIDTH must be >= 2 and SETTLE_CYCLES >= 1");
  end

`ifdef DSP_UPD_SETTLE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_SETTLE = 2'd2, S_DONE = 2'd3} state_t;
  localparam int            SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  logic [SW-1:0] r_settle_cnt, w_settle_cnt_next;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t               r_state, w_state_next;
  logic                 r_last_jtag, w_last_jtag_next;
  logic                 r_after_done;
  logic                 r_bcast, w_bcast_next;
  logic [CW-1:0]        r_lane, w_lane_next;
  logic                 r_strobe, w_strobe_next;
  logic                 r_wc_ack, w_wc_ack_next;
  logic                 r_jtag_ack, w_jtag_ack_next;
  logic                 r_sel_err, w_sel_err_next;
  logic                 r_busy;
  logic [2:0]           r_sel, w_sel_next;
  logic [CW-1:0]        r_chan, w_chan_next;
  logic [4:0]           r_tap, w_tap_next;
  logic [DATA_BITS-1:0] r_data, w_data_next;

  logic                 w_wc_eff, w_jtag_eff, w_grant_jtag, w_step;
  logic                 w_g_bcast;
  logic [2:0]           w_g_sel;
  logic [CW-1:0]        w_g_chan;
  logic [4:0]           w_g_tap;
  logic [DATA_BITS-1:0] w_g_data;

  // The requester acked in DONE is ignored for one IDLE cycle so a late-dropping req is not re-served.
  assign w_wc_eff     = wc_req   & ~(r_after_done & ~r_last_jtag);
  assign w_jtag_eff   = jtag_req & ~(r_after_done &  r_last_jtag);
  assign w_grant_jtag = w_jtag_eff & (~w_wc_eff | ~r_last_jtag);

  assign w_g_bcast = w_grant_jtag ? jtag_bcast : wc_bcast;
  assign w_g_sel   = w_grant_jtag ? jtag_sel   : wc_sel;
  assign w_g_chan  = w_grant_jtag ? jtag_chan  : wc_chan;
  assign w_g_tap   = w_grant_jtag ? jtag_tap   : wc_tap;
  assign w_g_data  = w_grant_jtag ? jtag_data  : wc_data;

  always_comb begin
    w_state_next     = r_state;
    w_last_jtag_next = r_last_jtag;
    w_bcast_next     = r_bcast;
    w_lane_next      = r_lane;
    w_sel_next       = r_sel;
    w_chan_next      = r_chan;
    w_tap_next       = r_tap;
    w_data_next      = r_data;
    w_strobe_next    = 1'b0;
    w_wc_ack_next    = 1'b0;
    w_jtag_ack_next  = 1'b0;
    w_sel_err_next   = 1'b0;
    w_step           = 1'b0;
`ifdef DSP_UPD_SETTLE_EN
    w_settle_cnt_next = r_settle_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_wc_eff | w_jtag_eff) begin
          w_last_jtag_next = w_grant_jtag;
          w_bcast_next     = w_g_bcast;
          w_lane_next      = '0;
          w_sel_next       = w_g_sel;
          w_tap_next       = (w_g_sel == SEL_CHAN_EST) ? w_g_tap : 5'd0;
          w_data_next      = w_g_data;
          if (w_g_sel > SEL_MAX) begin
            w_state_next    = S_DONE;
            w_wc_ack_next   = ~w_grant_jtag;
            w_jtag_ack_next = w_grant_jtag;
            w_sel_err_next  = 1'b1;
          end else begin
            w_state_next  = S_WRITE;
            w_strobe_next = 1'b1;
            w_chan_next   = w_g_bcast ? '0 : w_g_chan;
          end
        end
      end
`ifdef DSP_UPD_SETTLE_EN
      S_WRITE: begin
        w_state_next      = S_SETTLE;
        w_settle_cnt_next = '0;
      end
      S_SETTLE: begin
        if (r_settle_cnt == SETTLE_LAST) w_step = 1'b1;
        else                             w_settle_cnt_next = r_settle_cnt + 1'b1;
      end
`else
      S_WRITE: w_step = 1'b1;
`endif
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // A finished write either starts the next broadcast lane or closes the transaction.
    if (w_step) begin
      if (r_bcast && (r_lane != LAST_LANE)) begin
        w_lane_next   = r_lane + 1'b1;
        w_chan_next   = r_lane + 1'b1;
        w_strobe_next = 1'b1;
        w_state_next  = S_WRITE;
      end else begin
        w_state_next    = S_DONE;
        w_wc_ack_next   = ~r_last_jtag;
        w_jtag_ack_next = r_last_jtag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_jtag  <= 1'b0;
      r_after_done <= 1'b0;
      r_bcast      <= 1'b0;
      r_lane       <= '0;
      r_strobe     <= 1'b0;
      r_wc_ack     <= 1'b0;
      r_jtag_ack   <= 1'b0;
      r_sel_err    <= 1'b0;
      r_busy       <= 1'b0;
      r_sel        <= '0;
      r_chan       <= '0;
      r_tap        <= '0;
      r_data       <= '0;
`ifdef DSP_UPD_SETTLE_EN
      r_settle_cnt <= '0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_last_jtag  <= w_last_jtag_next;
      r_after_done <= (r_state == S_DONE);
      r_bcast      <= w_bcast_next;
      r_lane       <= w_lane_next;
      r_strobe     <= w_strobe_next;
      r_wc_ack     <= w_wc_ack_next;
      r_jtag_ack   <= w_jtag_ack_next;
      r_sel_err    <= w_sel_err_next;
      r_busy       <= (w_state_next != S_IDLE);
      r_sel        <= w_sel_next;
      r_chan       <= w_chan_next;
      r_tap        <= w_tap_next;
      r_data       <= w_data_next;
`ifdef DSP_UPD_SETTLE_EN
      r_settle_cnt <= w_settle_cnt_next;
`endif
    end
  end

  assign wc_ack     = r_wc_ack;
  assign jtag_ack   = r_jtag_ack;
  assign upd_strobe = r_strobe;
  assign upd_sel    = r_sel;
  assign upd_chan   = r_chan;
  assign upd_tap    = r_tap;
  assign upd_data   = r_data;
  assign busy       = r_busy;
  assign sel_err    = r_sel_err;

endmodule

// File: tb/tb_dsp_update_sequencer.sv
// Scoreboard bench for dsp_update_sequencer: stimulus pushes expected strobe/ack records,
// a negedge monitor pops and compares them whenever the DUT emits a strobe or ack.
`timescale 1ns/1ps
module tb_dsp_update_sequencer;
`ifdef DSP_UPD_SETTLE_EN
  localparam int ST = 4;
`else
  localparam int ST = 0;
`endif

  // {cycle[15:0], strobe, wc_ack, jtag_ack, sel_err, chan[3:0], sel[2:0], tap[4:0], data[15:0]}
  typedef logic [47:0] rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wc_req = 0, wc_bcast = 0, jtag_req = 0, jtag_bcast = 0;
  logic [2:0]  wc_sel = 0, jtag_sel = 0;
  logic [3:0]  wc_chan = 0, jtag_chan = 0;
  logic [4:0]  wc_tap = 0, jtag_tap = 0;
  logic [15:0] wc_data = 0, jtag_data = 0;
  logic        wc_ack, jtag_ack, upd_strobe, busy, sel_err;
  logic [2:0]  upd_sel;
  logic [3:0]  upd_chan;
  logic [4:0]  upd_tap;
  logic [15:0] upd_data;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   c0;
  rec_t exp_q[$];
  rec_t mon_act;

  dsp_update_sequencer #(.CHANNEL_WIDTH(16), .DATA_BITS(16), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .wc_req(wc_req), .wc_bcast(wc_bcast), .wc_sel(wc_sel), .wc_chan(wc_chan),
    .wc_tap(wc_tap), .wc_data(wc_data), .wc_ack(wc_ack),
    .jtag_req(jtag_req), .jtag_bcast(jtag_bcast), .jtag_sel(jtag_sel), .jtag_chan(jtag_chan),
    .jtag_tap(jtag_tap), .jtag_data(jtag_data), .jtag_ack(jtag_ack),
    .upd_strobe(upd_strobe), .upd_sel(upd_sel), .upd_chan(upd_chan), .upd_tap(upd_tap),
    .upd_data(upd_data), .busy(busy), .sel_err(sel_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s value=%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {upd_strobe, wc_ack, jtag_ack, sel_err, busy, upd_chan, upd_sel, upd_tap, upd_data}, 64'd0);
  endtask

  function automatic rec_t mk_strobe(input int c, input int chan, input int sel, input int tap, input int data);
    return {c[15:0], 4'b1000, chan[3:0], sel[2:0], tap[4:0], data[15:0]};
  endfunction

  function automatic rec_t mk_ack(input int c, input bit jtag, input bit err);
    return {c[15:0], 1'b0, ~jtag, jtag, err, 28'd0};
  endfunction

  task automatic set_req(input bit jtag, input bit bc, input int sel, input int chan, input int tap, input int data);
    if (jtag) begin
      jtag_req = 1; jtag_bcast = bc; jtag_sel = 3'(sel); jtag_chan = 4'(chan); jtag_tap = 5'(tap); jtag_data = 16'(data);
    end else begin
      wc_req = 1; wc_bcast = bc; wc_sel = 3'(sel); wc_chan = 4'(chan); wc_tap = 5'(tap); wc_data = 16'(data);
    end
  endtask

  task automatic wait_ack_drop(input bit jtag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (jtag ? jtag_ack : wc_ack) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout actual=no_ack required=%s_ack", jtag ? "jtag" : "wc");
    end
    if (jtag) jtag_req = 0; else wc_req = 0;
  endtask

  // Monitor: every strobe/ack/sel_err cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (upd_strobe || wc_ack || jtag_ack || sel_err)) begin
      mon_act = {cyc[15:0], upd_strobe, wc_ack, jtag_ack, sel_err,
                 upd_strobe ? {upd_chan, upd_sel, upd_tap, upd_data} : 28'd0};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h required=none", mon_act);
      end else begin
        check("scoreboard", mon_act, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 0;
    repeat (2) @(negedge clk);

    // Single wc write; tap ignored because sel != channel_est.
    c0 = cyc;
    set_req(0, 0, 2, 5, 9, 16'h0123);
    exp_q.push_back(mk_strobe(c0 + 1, 5, 2, 0, 16'h0123));
    exp_q.push_back(mk_ack(c0 + 2 + ST, 0, 0));
    @(negedge clk);
    check("busy_during_write", busy, 1);
    wait_ack_drop(0);
    @(negedge clk);
    check("busy_after_single", busy, 0);
    repeat (2) @(negedge clk);

    // Single jtag channel_est write carries its tap.
    c0 = cyc;
    set_req(1, 0, 3, 2, 7, 16'hBEEF);
    exp_q.push_back(mk_strobe(c0 + 1, 2, 3, 7, 16'hBEEF));
    exp_q.push_back(mk_ack(c0 + 2 + ST, 1, 0));
    wait_ack_drop(1);
    repeat (2) @(negedge clk);

    // Tie with jtag granted last: wc wins.
    c0 = cyc;
    set_req(0, 0, 0, 4, 0, 16'h1111);
    set_req(1, 0, 2, 6, 0, 16'h2222);
    exp_q.push_back(mk_strobe(c0 + 1, 4, 0, 0, 16'h1111));
    exp_q.push_back(mk_ack(c0 + 2 + ST, 0, 0));
    exp_q.push_back(mk_strobe(c0 + 4 + ST, 6, 2, 0, 16'h2222));
    exp_q.push_back(mk_ack(c0 + 5 + 2 * ST, 1, 0));
    fork
      wait_ack_drop(0);
      wait_ack_drop(1);
    join
    repeat (2) @(negedge clk);

    // jtag broadcast mlsd_shift: 16 ascending lanes, chan/tap inputs ignored.
    c0 = cyc;
    set_req(1, 1, 4, 9, 5, 3);
    for (int i = 0; i < 16; i++) exp_q.push_back(mk_strobe(c0 + 1 + i * (ST + 1), i, 4, 0, 3));
    exp_q.push_back(mk_ack(c0 + 1 + 15 * (ST + 1) + 1 + ST, 1, 0));
    wait_ack_drop(1);
    repeat (2) @(negedge clk);

    // Illegal sel: immediate ack with sel_err, no strobe.
    c0 = cyc;
    set_req(0, 0, 6, 1, 0, 16'hDEAD);
    exp_q.push_back(mk_ack(c0 + 1, 0, 1));
    wait_ack_drop(0);
    @(negedge clk);
    check("busy_after_illegal", busy, 0);
    repeat (2) @(negedge clk);

    // wc broadcast channel_est with tap 7.
    c0 = cyc;
    set_req(0, 1, 3, 0, 7, 16'h0F0F);
    for (int i = 0; i < 16; i++) exp_q.push_back(mk_strobe(c0 + 1 + i * (ST + 1), i, 3, 7, 16'h0F0F));
    exp_q.push_back(mk_ack(c0 + 1 + 15 * (ST + 1) + 1 + ST, 0, 0));
    wait_ack_drop(0);
    repeat (2) @(negedge clk);

    // Reset after the third broadcast strobe abandons the transaction.
    c0 = cyc;
    set_req(0, 1, 0, 0, 0, 16'h55AA);
    for (int i = 0; i < 3; i++) exp_q.push_back(mk_strobe(c0 + 1 + i * (ST + 1), i, 0, 0, 16'h55AA));
    while (cyc < c0 + 1 + 2 * (ST + 1)) @(negedge clk);
    #2 rst = 1;
    #1 check_zero("async_reset_outputs");
    wc_req = 0;
    @(negedge clk);
    check("scoreboard_after_reset", exp_q.size(), 0);
    rst = 0;
    repeat (5) @(negedge clk);
    check_zero("no_ack_after_reset");

    // Fresh single request after the abort, on the top lane.
    c0 = cyc;
    set_req(0, 0, 1, 15, 0, 16'hFFFF);
    exp_q.push_back(mk_strobe(c0 + 1, 15, 1, 0, 16'hFFFF));
    exp_q.push_back(mk_ack(c0 + 2 + ST, 0, 0));
    wait_ack_drop(0);
    repeat (2) @(negedge clk);

    // Tie right after reset: jtag first, then wc in the first IDLE after jtag_ack.
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    c0 = cyc;
    set_req(1, 0, 1, 1, 0, 16'h00A1);
    set_req(0, 0, 0, 3, 0, 16'h00B2);
    exp_q.push_back(mk_strobe(c0 + 1, 1, 1, 0, 16'h00A1));
    exp_q.push_back(mk_ack(c0 + 2 + ST, 1, 0));
    exp_q.push_back(mk_strobe(c0 + 4 + ST, 3, 0, 0, 16'h00B2));
    exp_q.push_back(mk_ack(c0 + 5 + 2 * ST, 0, 0));
    fork
      wait_ack_drop(1);
      wait_ack_drop(0);
    join

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
